swrite_engine_mc: RTL

- Parametrised successor to the single-shot SWRITE engine.
- Reads a DW-granular block from memory through an AXI read master and emits SRIO SWRITE packets on the ireq AXI-Stream. Packets are sized by parameter, and each request is optionally followed by a DOORBELL.
- Tracks the doorbell response with a timeout and reports completion or error status, so the register layer gets done/err without polling.

---
 rtl/swrite_engine_mc.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/swrite_engine_mc.sv
// swrite_engine_mc
//
// Reads a block of 64-bit words from memory through an AXI read master and
// emits it as SRIO SWRITE packets on the ireq AXI-Stream. Each packet is one
// header beat plus up to PKT_BEATS payload beats. The transfer can optionally
// be followed by a DOORBELL. The doorbell response is tracked with a timeout,
// and the outcome is reported as a one-cycle done pulse, with err raised in
// the same cycle if anything went wrong.
//
// Parameters:
//   BURST_LEN   AXI beats per full read burst (power of 2, 1..256)
//   PKT_BEATS   payload beats per full SWRITE packet (power of 2, 1..32)
//   SIZE_W      width of size_dw
//   TIMEOUT_CYC cycles to wait for the doorbell response; 0 disables
//
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   start                  one-cycle request, ignored while busy
//   src_addr, dst_addr     byte addresses, bits [2:0] ignored
//   size_dw                transfer length in 64-bit beats, minus 1
//   db_en, db_info         doorbell enable and info field
//   busy, done, err        status: busy level, done pulse, err pulse with done
//   m_axis_ireq_*          outbound SRIO request stream
//   s_axis_iresp_*         inbound SRIO response stream (always ready)
//   m_axi_ar*, m_axi_r*    AXI read address / data channels

module swrite_engine_mc #(
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned PKT_BEATS   = 32,
    parameter int unsigned SIZE_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [SIZE_W-1:0] size_dw,
    input  logic              db_en,
    input  logic [15:0]       db_info,
    output logic              busy,
    output logic              done,
    output logic              err,

    output logic              m_axis_ireq_tvalid,
    input  logic              m_axis_ireq_tready,
    output logic [63:0]       m_axis_ireq_tdata,
    output logic              m_axis_ireq_tlast,

    input  logic              s_axis_iresp_tvalid,
    output logic              s_axis_iresp_tready,
    input  logic [63:0]       s_axis_iresp_tdata,
    input  logic [7:0]        s_axis_iresp_tkeep,
    input  logic              s_axis_iresp_tlast,

    output logic [31:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [63:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    // Beat counts need one bit more than size_dw to hold size_dw+1.
    localparam int unsigned    CntW       = SIZE_W + 1;
    localparam logic [CntW-1:0] BurstLenC = CntW'(BURST_LEN);
    localparam logic [CntW-1:0] PktMask   = CntW'(PKT_BEATS - 1);
    localparam int unsigned    PktShift   = $clog2(PKT_BEATS);
    localparam logic [31:0]    BurstBytes = 32'(BURST_LEN * 8);
    localparam logic [31:0]    PktBytes   = 32'(PKT_BEATS * 8);
    localparam bit             ToEnable   = (TIMEOUT_CYC != 0);
    localparam logic [31:0]    ToLast     = 32'(TIMEOUT_CYC - 1);

    // SWRITE header upper word: ftype 6, prio 01; DOORBELL: ftype A, tid 0x81.
    localparam logic [31:0]    HeadTop    = {8'h00, 8'h60, 1'b0, 2'b01, 1'b0, 12'h000};
    localparam logic [31:0]    DbTop      = {8'h81, 8'hA0, 1'b0, 2'b01, 1'b0, 12'h000};

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StData,
        StDb,
        StWait,
        StFin
    } state_e;

    state_e state_q, state_d;

    // Request latched at start.
    logic [SIZE_W-1:0] size_q;
    logic              db_en_q;
    logic [15:0]       db_info_q;
    logic [31:0]       pkt_addr_q;

    // Packet side progress.
    logic [CntW-1:0]   beat_cnt_q;   // payload beats already forwarded
    logic [SIZE_W-1:0] pkt_left_q;   // packets still to send after the current one
    logic [31:0]       to_cnt_q;     // cycles spent in StWait
    logic              err_flag_q;   // sticky failure flag for this transfer

    // AR engine, runs ahead of the packet FSM.
    logic              ar_valid_q;
    logic [31:0]       ar_addr_q;
    logic [CntW-1:0]   ar_rem_q;     // beats not yet requested

    logic              accept;
    logic [CntW-1:0]   n_total;
    logic              ar_last;
    logic              ar_hs;
    logic              r_hs;
    logic              data_last;
    logic              pkt_end;
    logic              resp_hit;
    logic              resp_ok;
    logic              timeout;
    logic [63:0]       rdata_swap;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_iresp_tkeep, s_axis_iresp_tlast, s_axis_iresp_tdata[47:0],
                             m_axi_rlast, src_addr[2:0], dst_addr[2:0]};

    assign accept  = (state_q == StIdle) && start;
    assign n_total = {1'b0, size_dw} + CntW'(1);

    // ------------------------------------------------------------------
    // AR engine
    // ------------------------------------------------------------------
    // The final burst carries whatever is left; when N is a multiple of
    // BURST_LEN this is a full burst, so arlen = (N-1) mod BURST_LEN holds.
    assign ar_last       = (ar_rem_q <= BurstLenC);
    assign m_axi_arlen   = ar_last ? 8'(ar_rem_q - CntW'(1)) : 8'(BURST_LEN - 1);
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arvalid = ar_valid_q;
    assign ar_hs         = ar_valid_q && m_axi_arready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_rem_q   <= '0;
        end else if (accept) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= {src_addr[31:3], 3'b000};
            ar_rem_q   <= n_total;
        end else if (ar_hs) begin
            ar_addr_q <= ar_addr_q + BurstBytes;
            if (ar_last) begin
                ar_valid_q <= 1'b0;
                ar_rem_q   <= '0;
            end else begin
                ar_rem_q <= ar_rem_q - BurstLenC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    // SRIO payload is big-endian relative to the AXI little-endian word.
    always_comb begin
        rdata_swap = '0;
        for (int i = 0; i < 8; i++) begin
            rdata_swap[8*i +: 8] = m_axi_rdata[8*(7-i) +: 8];
        end
    end

    // Packets are aligned to beat 0, so the low bits of the beat count give
    // the position inside the current packet.
    assign data_last = (beat_cnt_q == {1'b0, size_q});
    assign pkt_end   = ((beat_cnt_q & PktMask) == PktMask) || data_last;
    assign r_hs      = (state_q == StData) && m_axi_rvalid && m_axis_ireq_tready;
    assign resp_hit  = s_axis_iresp_tvalid && (s_axis_iresp_tdata[63:56] == 8'h81);
    assign resp_ok   = (s_axis_iresp_tdata[55:48] == 8'hD0);
    // Fires in the cycle the counter would reach TIMEOUT_CYC.
    assign timeout   = ToEnable && (to_cnt_q == ToLast);

    always_comb begin
        state_d            = state_q;
        m_axis_ireq_tvalid = 1'b0;
        m_axis_ireq_tdata  = '0;
        m_axis_ireq_tlast  = 1'b0;
        m_axi_rready       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHead;
                end
            end
            StHead: begin
                m_axis_ireq_tvalid = 1'b1;
                m_axis_ireq_tdata  = {HeadTop, pkt_addr_q};
                if (m_axis_ireq_tready) begin
                    state_d = StData;
                end
            end
            StData: begin
                m_axis_ireq_tvalid = m_axi_rvalid;
                m_axis_ireq_tdata  = rdata_swap;
                m_axis_ireq_tlast  = pkt_end;
                m_axi_rready       = m_axis_ireq_tready;
                if (r_hs && pkt_end) begin
                    if (pkt_left_q != '0) begin
                        state_d = StHead;
                    end else if (db_en_q) begin
                        state_d = StDb;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StDb: begin
                m_axis_ireq_tvalid = 1'b1;
                m_axis_ireq_tlast  = 1'b1;
                m_axis_ireq_tdata  = {DbTop, db_info_q, 16'h0000};
                if (m_axis_ireq_tready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response in the expiry cycle wins over the timeout.
                if (resp_hit || timeout) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            size_q     <= '0;
            db_en_q    <= 1'b0;
            db_info_q  <= '0;
            pkt_addr_q <= '0;
            beat_cnt_q <= '0;
            pkt_left_q <= '0;
            to_cnt_q   <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                size_q     <= size_dw;
                db_en_q    <= db_en;
                db_info_q  <= db_info;
                pkt_addr_q <= {dst_addr[31:3], 3'b000};
                beat_cnt_q <= '0;
                // ceil((size_dw+1)/PKT_BEATS) - 1
                pkt_left_q <= size_dw >> PktShift;
            end else if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + CntW'(1);
                if (pkt_end) begin
                    pkt_addr_q <= pkt_addr_q + PktBytes;
                    if (pkt_left_q != '0) begin
                        pkt_left_q <= pkt_left_q - SIZE_W'(1);
                    end
                end
            end

            if (state_q == StWait) begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end else begin
                to_cnt_q <= '0;
            end

            if (accept) begin
                err_flag_q <= 1'b0;
            end else if (r_hs && (m_axi_rresp != 2'b00)) begin
                err_flag_q <= 1'b1;
            end else if (state_q == StWait) begin
                if (resp_hit) begin
                    if (!resp_ok) begin
                        err_flag_q <= 1'b1;
                    end
                end else if (timeout) begin
                    err_flag_q <= 1'b1;
                end
            end
        end
    end

    assign busy                = (state_q != StIdle);
    assign done                = (state_q == StFin);
    assign err                 = (state_q == StFin) && err_flag_q;
    assign s_axis_iresp_tready = 1'b1;

endmodule
